// File: rtl/item_table_double_buffer_pkg.sv
// Shared widths, field positions and FSM encoding for the item table and its write checkers.
package item_table_double_buffer_pkg;

  localparam int ITEM_W    = 14;
  localparam int NUM_SLOTS = 9;
  localparam int NUM_TILES = 192;
  localparam int SLOT_W    = 4;
  localparam int LOC_W     = 8;

  localparam int ID_MSB  = 13;
  localparam int ID_LSB  = 10;
  localparam int ORI_MSB = 9;
  localparam int ORI_LSB = 8;
  localparam int LOC_MSB = 7;
  localparam int LOC_LSB = 0;

  localparam logic [ITEM_W-1:0]        UNUSED_ITEM = 14'h3C00;
  localparam logic [ID_MSB-ID_LSB:0]   ID_UNUSED   = 4'hF;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

endpackage

// File: rtl/item_write_checker.sv
// Combinational legality check for a slot write; zero latency, no flow control of its own.
module item_write_checker
  import item_table_double_buffer_pkg::*;
(
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [ITEM_W-1:0] wr_item,
  output logic              slot_ok,
  output logic              loc_ok
);

  assign slot_ok = (wr_slot != '0) && (wr_slot <= SLOT_W'(NUM_SLOTS));

  // A slot clear (ID F) carries no meaningful location, so it is always legal.
  assign loc_ok = (wr_item[LOC_MSB:LOC_LSB] < LOC_W'(NUM_TILES)) ||
                  (wr_item[ID_MSB:ID_LSB] == ID_UNUSED);

endmodule

// File: rtl/item_table_double_buffer.sv
// Shadow/active item table: writes land in shadow next edge; a commit copies shadow to active
// at the swap point one edge later. Writes stall (wr_ready=0) while a commit is pending.
module item_table_double_buffer
  import item_table_double_buffer_pkg::*;
#(
  parameter int unsigned SWAP_LINE  = 480,
  parameter int unsigned SWAP_PIXEL = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [ITEM_W-1:0] wr_item,
  output logic              wr_err,
  input  logic              commit,
  output logic              commit_pending,
  input  logic [9:0]        counter_V,
  input  logic [9:0]        counter_H,
  output logic              frame_swapped,
  output logic [ITEM_W-1:0] item_1,
  output logic [ITEM_W-1:0] item_2,
  output logic [ITEM_W-1:0] item_3,
  output logic [ITEM_W-1:0] item_4,
  output logic [ITEM_W-1:0] item_5,
  output logic [ITEM_W-1:0] item_6,
  output logic [ITEM_W-1:0] item_7,
  output logic [ITEM_W-1:0] item_8,
  output logic [ITEM_W-1:0] item_9
);

  logic [ITEM_W-1:0] shadow_q [1:NUM_SLOTS];
  logic [ITEM_W-1:0] active_q [1:NUM_SLOTS];
  state_t            state_q;
  logic              wr_err_q;
  logic              frame_swapped_q;

  logic slot_ok;
  logic loc_ok;
  logic wr_accept;
  logic swap_hit;

  item_write_checker u_checker (
    .wr_slot (wr_slot),
    .wr_item (wr_item),
    .slot_ok (slot_ok),
    .loc_ok  (loc_ok)
  );

  assign wr_ready  = !reset && (state_q == ST_IDLE);
  assign wr_accept = wr_valid && wr_ready;
  assign swap_hit  = (counter_V == 10'(SWAP_LINE)) && (counter_H == 10'(SWAP_PIXEL));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i <= NUM_SLOTS; i++) begin
        shadow_q[i] <= UNUSED_ITEM;
        active_q[i] <= UNUSED_ITEM;
      end
      state_q         <= ST_IDLE;
      wr_err_q        <= 1'b0;
      frame_swapped_q <= 1'b0;
    end else begin
      wr_err_q        <= wr_accept && !(slot_ok && loc_ok);
      frame_swapped_q <= 1'b0;

      if (wr_accept && slot_ok && loc_ok) begin
        for (int i = 1; i <= NUM_SLOTS; i++) begin
          if (wr_slot == SLOT_W'(i)) shadow_q[i] <= wr_item;
        end
      end

      // Shadow is frozen while pending (wr_ready low), so the copy is the committed image.
      case (state_q)
        ST_IDLE: begin
          if (commit) state_q <= ST_PENDING;
        end
        ST_PENDING: begin
          if (swap_hit) begin
            active_q        <= shadow_q;
            frame_swapped_q <= 1'b1;
            state_q         <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wr_err         = wr_err_q;
  assign frame_swapped  = frame_swapped_q;
  assign commit_pending = (state_q == ST_PENDING);

  assign item_1 = active_q[1];
  assign item_2 = active_q[2];
  assign item_3 = active_q[3];
  assign item_4 = active_q[4];
  assign item_5 = active_q[5];
  assign item_6 = active_q[6];
  assign item_7 = active_q[7];
  assign item_8 = active_q[8];
  assign item_9 = active_q[9];

endmodule

// File: tb/tb_item_table_double_buffer.sv
// Bench for the double-buffered item table: vector table for write legality, scoreboard of committed images.
module tb_item_table_double_buffer;
  import item_table_double_buffer_pkg::*;

  typedef logic [NUM_SLOTS*ITEM_W-1:0] img_t;
  typedef struct {
    logic [3:0]  slot;
    logic [13:0] item;
    logic        exp_err;
    string       name;
  } wvec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_slot;
  logic [13:0] wr_item;
  logic        wr_err;
  logic        commit;
  logic        commit_pending;
  logic [9:0]  counter_V;
  logic [9:0]  counter_H;
  logic        frame_swapped;
  logic [13:0] item_1, item_2, item_3, item_4, item_5, item_6, item_7, item_8, item_9;
  logic [13:0] dut_item [1:9];

  always #5 clk = ~clk;

  item_table_double_buffer dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_slot(wr_slot), .wr_item(wr_item), .wr_err(wr_err), .commit(commit),
    .commit_pending(commit_pending), .counter_V(counter_V), .counter_H(counter_H),
    .frame_swapped(frame_swapped),
    .item_1(item_1), .item_2(item_2), .item_3(item_3), .item_4(item_4), .item_5(item_5),
    .item_6(item_6), .item_7(item_7), .item_8(item_8), .item_9(item_9)
  );

  assign dut_item[1] = item_1;
  assign dut_item[2] = item_2;
  assign dut_item[3] = item_3;
  assign dut_item[4] = item_4;
  assign dut_item[5] = item_5;
  assign dut_item[6] = item_6;
  assign dut_item[7] = item_7;
  assign dut_item[8] = item_8;
  assign dut_item[9] = item_9;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [13:0] m_shadow [1:9];
  logic [13:0] m_active [1:9];
  logic        m_pend;
  logic        exp_err;
  logic        exp_swap;
  img_t        sb [$];

  function automatic img_t shadow_img();
    img_t r;
    for (int i = 1; i <= 9; i++) r[(i-1)*14 +: 14] = m_shadow[i];
    return r;
  endfunction

  function automatic img_t active_img();
    img_t r;
    for (int i = 1; i <= 9; i++) r[(i-1)*14 +: 14] = m_active[i];
    return r;
  endfunction

  function automatic img_t dut_img();
    img_t r;
    for (int i = 1; i <= 9; i++) r[(i-1)*14 +: 14] = dut_item[i];
    return r;
  endfunction

  task automatic chk(input string name, input img_t act, input img_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: model the cycle from the driven inputs, then compare after the edge.
  task automatic cyc();
    logic good;
    #2;
    chk("wr_ready", img_t'(wr_ready), img_t'(!reset && !m_pend));
    exp_err  = 1'b0;
    exp_swap = 1'b0;
    if (reset) begin
      for (int i = 1; i <= 9; i++) begin
        m_shadow[i] = 14'h3C00;
        m_active[i] = 14'h3C00;
      end
      m_pend = 1'b0;
      sb.delete();
    end else if (!m_pend) begin
      if (wr_valid) begin
        good = (wr_slot >= 4'd1) && (wr_slot <= 4'd9) &&
               ((wr_item[7:0] < 8'd192) || (wr_item[13:10] == 4'hF));
        if (good) m_shadow[wr_slot] = wr_item;
        exp_err = !good;
      end
      if (commit) begin
        m_pend = 1'b1;
        sb.push_back(shadow_img());
      end
    end else if (counter_V == 10'd480 && counter_H == 10'd0) begin
      for (int i = 1; i <= 9; i++) m_active[i] = m_shadow[i];
      exp_swap = 1'b1;
      m_pend   = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("wr_err", img_t'(wr_err), img_t'(exp_err));
    chk("frame_swapped", img_t'(frame_swapped), img_t'(exp_swap));
    chk("commit_pending", img_t'(commit_pending), img_t'(m_pend));
    chk("active_items", dut_img(), active_img());
    if (frame_swapped === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_swap actual=1 required=0");
      end else begin
        chk("sb_swap_image", dut_img(), sb.pop_front());
      end
    end
  endtask

  task automatic tick(input logic [9:0] v, input logic [9:0] h, input logic vld,
                      input logic [3:0] slot, input logic [13:0] item, input logic cmt);
    counter_V = v;
    counter_H = h;
    wr_valid  = vld;
    wr_slot   = slot;
    wr_item   = item;
    commit    = cmt;
    cyc();
  endtask

  wvec_t vecs [8];

  initial begin
    vecs[0] = '{4'd0,  14'h0512, 1'b1, "rej_slot0"};
    vecs[1] = '{4'd10, 14'h0512, 1'b1, "rej_slot10"};
    vecs[2] = '{4'd2,  14'h04C0, 1'b1, "rej_loc192"};
    vecs[3] = '{4'd2,  14'h3CFF, 1'b0, "ok_clear_id_f"};
    vecs[4] = '{4'd15, 14'h3C00, 1'b1, "rej_slot15"};
    vecs[5] = '{4'd1,  14'h08C0, 1'b1, "rej_loc192_id2"};
    vecs[6] = '{4'd9,  14'h0BBF, 1'b0, "ok_loc191"};
    vecs[7] = '{4'd4,  14'h3CC8, 1'b0, "ok_clear_loc200"};

    for (int i = 1; i <= 9; i++) begin
      m_shadow[i] = 14'h3C00;
      m_active[i] = 14'h3C00;
    end
    m_pend = 1'b0;
    reset  = 1'b1;

    tick(10'd0, 10'd0, 1'b0, 4'd0, 14'h0, 1'b0);
    tick(10'd0, 10'd0, 1'b0, 4'd0, 14'h0, 1'b0);
    reset = 1'b0;
    tick(10'd0, 10'd1, 1'b0, 4'd0, 14'h0, 1'b0);
    chk("reset_item_1", img_t'(item_1), img_t'(14'h3C00));

    foreach (vecs[k]) begin
      tick(10'd100, 10'd5, 1'b1, vecs[k].slot, vecs[k].item, 1'b0);
      chk(vecs[k].name, img_t'(wr_err), img_t'(vecs[k].exp_err));
      tick(10'd100, 10'd6, 1'b0, 4'd0, 14'h0, 1'b0);
    end

    // Basic swap on slot 3
    tick(10'd100, 10'd0, 1'b1, 4'd3, 14'h0512, 1'b0);
    tick(10'd100, 10'd1, 1'b0, 4'd0, 14'h0, 1'b1);
    chk("basic_pending", img_t'(commit_pending), img_t'(1'b1));
    tick(10'd200, 10'd0, 1'b0, 4'd0, 14'h0, 1'b0);
    tick(10'd479, 10'd0, 1'b0, 4'd0, 14'h0, 1'b0);
    tick(10'd480, 10'd1, 1'b0, 4'd0, 14'h0, 1'b0);
    chk("basic_item3_held", img_t'(item_3), img_t'(14'h3C00));
    tick(10'd480, 10'd0, 1'b0, 4'd0, 14'h0, 1'b0);
    chk("basic_item3_swapped", img_t'(item_3), img_t'(14'h0512));
    chk("basic_swap_pulse", img_t'(frame_swapped), img_t'(1'b1));
    tick(10'd480, 10'd0, 1'b0, 4'd0, 14'h0, 1'b0);
    chk("basic_swap_once", img_t'(frame_swapped), img_t'(1'b0));

    // Writes stall while pending
    tick(10'd100, 10'd0, 1'b0, 4'd0, 14'h0, 1'b1);
    for (int i = 0; i < 3; i++) tick(10'd300, 10'(i), 1'b1, 4'd5, 14'h0801, 1'b0);
    tick(10'd480, 10'd0, 1'b1, 4'd5, 14'h0801, 1'b0);
    tick(10'd481, 10'd0, 1'b1, 4'd5, 14'h0801, 1'b0);
    tick(10'd10, 10'd0, 1'b0, 4'd0, 14'h0, 1'b0);
    chk("stall_item5_not_yet", img_t'(item_5), img_t'(14'h3C00));
    tick(10'd20, 10'd0, 1'b0, 4'd0, 14'h0, 1'b1);
    tick(10'd480, 10'd0, 1'b0, 4'd0, 14'h0, 1'b0);
    chk("stall_item5_swapped", img_t'(item_5), img_t'(14'h0801));

    // Commit raised on the swap point itself waits a full frame
    tick(10'd100, 10'd0, 1'b1, 4'd1, 14'h0C05, 1'b0);
    tick(10'd480, 10'd0, 1'b0, 4'd0, 14'h0, 1'b1);
    chk("edge_no_swap", img_t'(frame_swapped), img_t'(1'b0));
    tick(10'd480, 10'd1, 1'b0, 4'd0, 14'h0, 1'b0);
    tick(10'd0, 10'd0, 1'b0, 4'd0, 14'h0, 1'b0);
    chk("edge_item1_held", img_t'(item_1), img_t'(14'h3C00));
    tick(10'd480, 10'd0, 1'b0, 4'd0, 14'h0, 1'b0);
    chk("edge_item1_swapped", img_t'(item_1), img_t'(14'h0C05));

    // Write and commit in the same cycle
    tick(10'd50, 10'd0, 1'b1, 4'd9, 14'h1307, 1'b1);
    tick(10'd480, 10'd0, 1'b0, 4'd0, 14'h0, 1'b0);
    chk("same_cycle_item9", img_t'(item_9), img_t'(14'h1307));

    // Reset while pending drops the commit
    tick(10'd50, 10'd0, 1'b1, 4'd4, 14'h0410, 1'b1);
    chk("rst_pending_set", img_t'(commit_pending), img_t'(1'b1));
    reset = 1'b1;
    tick(10'd480, 10'd0, 1'b0, 4'd0, 14'h0, 1'b0);
    reset = 1'b0;
    tick(10'd100, 10'd0, 1'b0, 4'd0, 14'h0, 1'b0);
    tick(10'd480, 10'd0, 1'b0, 4'd0, 14'h0, 1'b0);
    chk("rst_no_swap", img_t'(frame_swapped), img_t'(1'b0));
    chk("rst_item9_cleared", img_t'(item_9), img_t'(14'h3C00));
    chk("rst_item4_cleared", img_t'(item_4), img_t'(14'h3C00));

    chk("sb_drained", img_t'(sb.size()), img_t'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
